// File: rtl/xbar_switch_2x2.sv
// xbar_switch_2x2: registered 2x2 switch for WIDTH-bit flits.
// Each input port has a one-entry slot. When both slots want the same output,
// an arbiter picks a winner. Two registered output ports use valid/ready handshakes.
// The `control` output records the crossbar select of the latest routing.
// Optional build macro XBAR_SWITCH_RR_EN selects round-robin arbitration.
// When the macro is not defined, in1 always wins a conflict.

// One input slot: a single {data, dest, full} entry with pass-through refill.
module xbar_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dest,
  input  logic             move,
  output logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             dest
);

  // The slot can take a new flit while its current flit leaves.
  assign ready = !full | move;

  // A new flit takes priority over emptying the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
      dest <= 1'b0;
    end else if (load_valid & ready) begin
      full <= 1'b1;
      data <= load_data;
      dest <= load_dest;
    end else if (move) begin
      full <= 1'b0;
    end
  end

endmodule

module xbar_switch_2x2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_dest,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_dest,
  output logic             in2_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic             out2_valid,
  output logic [WIDTH-1:0] out2_data,
  input  logic             out2_ready,
  output logic             control
);

  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]            port_valid, port_dest, slot_ready;
  logic [NUM_PORTS-1:0][WIDTH-1:0] port_data, slot_data;
  logic [NUM_PORTS-1:0]            slot_full, slot_dest;
  logic [NUM_PORTS-1:0]            out_valid, out_ready, out_free;
  logic [NUM_PORTS-1:0][WIDTH-1:0] out_data;
  logic [NUM_PORTS-1:0]            elig, move;
  logic                            conflict, win;

  assign port_valid = {in2_valid, in1_valid};
  assign port_dest  = {in2_dest,  in1_dest};
  assign port_data  = {in2_data,  in1_data};
  assign out_ready  = {out2_ready, out1_ready};

  assign in1_ready  = slot_ready[0];
  assign in2_ready  = slot_ready[1];
  assign out1_valid = out_valid[0];
  assign out2_valid = out_valid[1];
  assign out1_data  = out_data[0];
  assign out2_data  = out_data[1];

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_slot
      xbar_slot #(.WIDTH(WIDTH)) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (port_valid[g]),
        .load_data  (port_data[g]),
        .load_dest  (port_dest[g]),
        .move       (move[g]),
        .ready      (slot_ready[g]),
        .full       (slot_full[g]),
        .data       (slot_data[g]),
        .dest       (slot_dest[g])
      );
    end
  endgenerate

  // An output is free if it is empty, or if its flit is drained in this cycle.
  assign out_free = ~out_valid | out_ready;

`ifdef XBAR_SWITCH_RR_EN
  logic ptr;  // 0 = in1 wins the next conflict, 1 = in2 wins

  assign win = ptr;

  // After a conflict, the loser gets priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ptr <= 1'b0;
    else if (conflict) ptr <= !win;
  end
`else
  assign win = 1'b0;
`endif

  // Arbitration: eligibility, conflict detection and per-slot move.
  always_comb begin
    elig[0]  = slot_full[0] & out_free[slot_dest[0]];
    elig[1]  = slot_full[1] & out_free[slot_dest[1]];
    conflict = elig[0] & elig[1] & (slot_dest[0] == slot_dest[1]);
    move[0]  = elig[0] & (!conflict | !win);
    move[1]  = elig[1] & (!conflict |  win);
  end

  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_out
      localparam logic J = 1'(g);
      logic             load;
      logic [WIDTH-1:0] load_data;

      // At most one slot moves into this output, because arbitration
      // has already resolved same-destination conflicts.
      always_comb begin
        load      = (move[0] & (slot_dest[0] == J)) | (move[1] & (slot_dest[1] == J));
        load_data = (move[0] & (slot_dest[0] == J)) ? slot_data[0] : slot_data[1];
      end

      // A load takes priority over a drain. Data holds while the flit is stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid[g] <= 1'b0;
          out_data[g]  <= '0;
        end else if (load) begin
          out_valid[g] <= 1'b1;
          out_data[g]  <= load_data;
        end else if (out_ready[g]) begin
          out_valid[g] <= 1'b0;
        end
      end
    end
  endgenerate

  // The crossbar select follows in1 when it moves; otherwise it is derived from in2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       control <= 1'b0;
    else if (move[0]) control <= slot_dest[0];
    else if (move[1]) control <= !slot_dest[1];
  end

endmodule

// File: tb/tb_xbar_switch_2x2.sv
// Directed self-checking bench for xbar_switch_2x2.
// The bench checks conflict ordering for the build selected by XBAR_SWITCH_RR_EN.
module tb_xbar_switch_2x2;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in1_valid, in2_valid, in1_dest, in2_dest;
  logic [WIDTH-1:0] in1_data, in2_data;
  logic             in1_ready, in2_ready;
  logic             out1_valid, out2_valid, out1_ready, out2_ready;
  logic [WIDTH-1:0] out1_data, out2_data;
  logic             control;

  int total  = 0;
  int passes = 0;

  xbar_switch_2x2 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in1_valid  (in1_valid),
    .in1_data   (in1_data),
    .in1_dest   (in1_dest),
    .in1_ready  (in1_ready),
    .in2_valid  (in2_valid),
    .in2_data   (in2_data),
    .in2_dest   (in2_dest),
    .in2_ready  (in2_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .out2_valid (out2_valid),
    .out2_data  (out2_data),
    .out2_ready (out2_ready),
    .control    (control)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in1_valid = 1'b0;
    in2_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] first_d, second_d;
  logic             first_ctl, second_ctl, loser_rdy1, loser_rdy2;
  int               got1, got2;

  initial begin
    rst_n      = 1'b0;
    in1_valid  = 1'b0; in1_data = '0; in1_dest = 1'b0;
    in2_valid  = 1'b0; in2_data = '0; in2_dest = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    step(); step();
    check("rst_in1_ready", in1_ready, 1);
    check("rst_in2_ready", in2_ready, 1);
    check("rst_out1_valid", out1_valid, 0);
    check("rst_out2_valid", out2_valid, 0);
    check("rst_out1_data", out1_data, 0);
    check("rst_control", control, 0);
    rst_n = 1'b1;
    step();
    check("idle_in1_ready", in1_ready, 1);
    check("idle_out2_valid", out2_valid, 0);

    // Straight routing
    in1_valid = 1; in1_data = 4'h3; in1_dest = 0;
    in2_valid = 1; in2_data = 4'hC; in2_dest = 1;
    step(); idle_inputs(); step();
    check("str_out1_valid", out1_valid, 1);
    check("str_out1_data", out1_data, 4'h3);
    check("str_out2_data", out2_data, 4'hC);
    check("str_control", control, 0);

    // Cross routing
    in1_valid = 1; in1_data = 4'h3; in1_dest = 1;
    in2_valid = 1; in2_data = 4'hC; in2_dest = 0;
    step(); idle_inputs(); step();
    check("crs_out1_data", out1_data, 4'hC);
    check("crs_out2_data", out2_data, 4'h3);
    check("crs_control", control, 1);
    step();
    check("crs_drain_out1", out1_valid, 0);
    check("crs_drain_out2", out2_valid, 0);

    // First conflict: in1 wins in both builds
    in1_valid = 1; in1_data = 4'h5; in1_dest = 1;
    in2_valid = 1; in2_data = 4'h9; in2_dest = 1;
    step(); idle_inputs();
    check("cf1_in1_ready", in1_ready, 1);
    check("cf1_in2_ready", in2_ready, 0);
    step();
    check("cf1_a_data", out2_data, 4'h5);
    check("cf1_a_valid", out2_valid, 1);
    check("cf1_a_ctl", control, 1);
    check("cf1_in2_ready_back", in2_ready, 1);
    step();
    check("cf1_b_data", out2_data, 4'h9);
    check("cf1_b_ctl", control, 0);
    step();
    check("cf1_drain", out2_valid, 0);

    // Second conflict: the winner depends on the arbitration mode
`ifdef XBAR_SWITCH_RR_EN
    first_d = 4'h9; second_d = 4'h5; first_ctl = 0; second_ctl = 1;
    loser_rdy1 = 0; loser_rdy2 = 1;
`else
    first_d = 4'h5; second_d = 4'h9; first_ctl = 1; second_ctl = 0;
    loser_rdy1 = 1; loser_rdy2 = 0;
`endif
    in1_valid = 1; in1_data = 4'h5; in1_dest = 1;
    in2_valid = 1; in2_data = 4'h9; in2_dest = 1;
    step(); idle_inputs();
    check("cf2_in1_ready", in1_ready, loser_rdy1);
    check("cf2_in2_ready", in2_ready, loser_rdy2);
    step();
    check("cf2_a_data", out2_data, first_d);
    check("cf2_a_ctl", control, first_ctl);
    step();
    check("cf2_b_data", out2_data, second_d);
    check("cf2_b_ctl", control, second_ctl);
    step();

    // Back-pressure on out1 while in1 streams 1, 2, 3
    out1_ready = 0;
    in1_valid = 1; in1_data = 4'h1; in1_dest = 0;
    step();                                   // edge 1: accept 1
    in1_data = 4'h2;
    check("bp_rdy_e1", in1_ready, 1);
    step();                                   // edge 2: 1 -> out1, accept 2
    in1_data = 4'h3;
    check("bp_out_e2", out1_data, 4'h1);
    check("bp_ctl_e2", control, 0);
    check("bp_rdy_e2", in1_ready, 0);
    for (int k = 3; k <= 5; k++) begin
      step();
      check("bp_hold_valid", out1_valid, 1);
      check("bp_hold_data", out1_data, 4'h1);
      check("bp_hold_rdy", in1_ready, 0);
    end
    out1_ready = 1;
    #1;
    check("bp_release_rdy", in1_ready, 1);
    step(); in1_valid = 0;                    // edge 6: 2 -> out1, accept 3
    check("bp_out_2", out1_data, 4'h2);
    step();
    check("bp_out_3", out1_data, 4'h3);
    check("bp_out_3v", out1_valid, 1);
    step();
    check("bp_empty", out1_valid, 0);

    // Throughput: 16 flits per port to distinct outputs
    got1 = 0; got2 = 0;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin
        in1_valid = 1; in1_data = 4'(k);      in1_dest = 0;
        in2_valid = 1; in2_data = 4'(15 - k); in2_dest = 1;
        #1;
        check("tp_rdy1", in1_ready, 1);
        check("tp_rdy2", in2_ready, 1);
      end else begin
        idle_inputs();
      end
      step();
      if (k >= 1) begin
        check("tp_out1", {out1_valid, out1_data}, {1'b1, 4'(k - 1)});
        check("tp_out2", {out2_valid, out2_data}, {1'b1, 4'(16 - k)});
        if (out1_valid) got1++;
        if (out2_valid) got2++;
      end
    end
    check("tp_count1", 8'(got1), 16);
    check("tp_count2", 8'(got2), 16);
    step();
    check("tp_idle", out1_valid, 0);

    // Asynchronous reset in the middle of operation
    in1_valid = 1; in1_data = 4'hA; in1_dest = 0;
    step();
    out1_ready = 0; in1_data = 4'hB;
    step();                                   // A -> out1, accept B
    idle_inputs();
    check("ar_out1_A", out1_data, 4'hA);
    check("ar_in1_full", in1_ready, 0);
    #2 rst_n = 0;
    #1;
    check("ar_out1_valid", out1_valid, 0);
    check("ar_out1_data", out1_data, 0);
    check("ar_in1_ready", in1_ready, 1);
    check("ar_control", control, 0);
    step();
    rst_n = 1; out1_ready = 1;
    step(); step();
    check("ar_no_ghost", out1_valid, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
